// File: rtl/verlet_chain_if.sv
// verlet_chain_if: bundles the control, boundary and readout signals of one
// verlet_chain_core. master = controller side (drives start, pins, boundary
// nodes, rd_idx); slave = core side (drives busy, done, end nodes, readout).
interface verlet_chain_if #(
  parameter int N = 5,
  parameter int W = 32
);
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  // step handshake
  logic                start;
  logic                busy;
  logic                done;
  // endpoint pinning
  logic                pin_first;
  logic                pin_last;
  // neighbour cores' end nodes
  logic signed [W-1:0] prev_last_x;
  logic signed [W-1:0] prev_last_y;
  logic signed [W-1:0] next_first_x;
  logic signed [W-1:0] next_first_y;
  // this core's end nodes
  logic signed [W-1:0] first_x;
  logic signed [W-1:0] first_y;
  logic signed [W-1:0] last_x;
  logic signed [W-1:0] last_y;
  // random-access readout
  logic [KW-1:0]       rd_idx;
  logic signed [W-1:0] rd_x;
  logic signed [W-1:0] rd_y;

  modport master (
    output start, pin_first, pin_last,
    output prev_last_x, prev_last_y, next_first_x, next_first_y,
    output rd_idx,
    input  busy, done, first_x, first_y, last_x, last_y, rd_x, rd_y
  );

  modport slave (
    input  start, pin_first, pin_last,
    input  prev_last_x, prev_last_y, next_first_x, next_first_y,
    input  rd_idx,
    output busy, done, first_x, first_y, last_x, last_y, rd_x, rd_y
  );
endinterface

// File: rtl/verlet_chain_core.sv
// verlet_chain_core: register-resident chain of N point masses. Each accepted
// start runs one Verlet integration sweep (one node per cycle) followed by
// ITERS Gauss-Seidel relaxation sweeps against the neighbours, then pulses done.
// Latency: start at edge t -> busy t+1..t+N+ITERS*N, done at t+N+ITERS*N+1.
// start is only accepted in IDLE; starts while busy or during done are dropped.
//
// Ports: clk, reset (synchronous, active-low) and bus (verlet_chain_if.slave):
//   start/busy/done handshake, pin_first/pin_last, neighbour end nodes
//   prev_last_*/next_first_*, own end nodes first_*/last_*, readout
//   rd_idx -> rd_x/rd_y (combinational, 0 for rd_idx >= N).
// Build option: define VERLET_DAMP_EN to integrate with velocity damping
//   (v - (v >>> DAMP_SHIFT)); without it DAMP_SHIFT has no effect.
module verlet_chain_core #(
  parameter int                  N           = 5,
  parameter int                  W           = 32,
  parameter logic [W-1:0]        SPACING     = W'(32'h0001_0000),
  parameter logic signed [W-1:0] ACC_Y       = W'(-32'sh100),
  parameter int                  ITERS       = 2,
  parameter int                  STIFF_SHIFT = 0,
  parameter int                  DAMP_SHIFT  = 4
) (
  input  logic          clk,
  input  logic          reset,
  verlet_chain_if.slave bus
);

  localparam int KW = $clog2(N);
  localparam int IW = (ITERS > 1) ? $clog2(ITERS) : 1;

  // Elaboration-time parameter sanity checks.
  if (N < 2) begin : g_bad_n
    $error("verlet_chain_core: N must be >= 2");
  end
  if (ITERS < 1) begin : g_bad_iters
    $error("verlet_chain_core: ITERS must be >= 1");
  end
  if (DAMP_SHIFT < 0 || DAMP_SHIFT >= W) begin : g_bad_damp
    $error("verlet_chain_core: DAMP_SHIFT out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_INTEGRATE = 2'd1,
    S_RELAX     = 2'd2,
    S_DONE      = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;          // node currently processed
  logic [IW-1:0]       it_q, it_d;        // relaxation sweep number

  logic signed [W-1:0] x_q  [N];
  logic signed [W-1:0] x_d  [N];
  logic signed [W-1:0] y_q  [N];
  logic signed [W-1:0] y_d  [N];
  logic signed [W-1:0] px_q [N];
  logic signed [W-1:0] px_d [N];
  logic signed [W-1:0] py_q [N];
  logic signed [W-1:0] py_d [N];

  // Neighbour end nodes captured at start so the step sees a stable boundary.
  logic signed [W-1:0] bl_x_q, bl_x_d, bl_y_q, bl_y_d;
  logic signed [W-1:0] br_x_q, br_x_d, br_y_q, br_y_d;

  // One Verlet position update for a single axis (ACC_Y added by the caller).
  function automatic logic signed [W-1:0] integ_f(
    input logic signed [W-1:0] c,
    input logic signed [W-1:0] p
  );
`ifdef VERLET_DAMP_EN
    logic signed [W-1:0] v;
    v = c - p;
    return c + v - (v >>> DAMP_SHIFT);
`else
    return (c <<< 1) - p;
`endif
  endfunction

  // Pull c toward the midpoint of its neighbours. The neighbour sum is formed
  // in W+1 bits so it cannot overflow; dropping its LSB is the arithmetic >>>1.
  function automatic logic signed [W-1:0] relax_f(
    input logic signed [W-1:0] l,
    input logic signed [W-1:0] r,
    input logic signed [W-1:0] c
  );
    logic signed [W:0]   sum;
    logic signed [W-1:0] avg;
    logic signed [W-1:0] diff;
    sum  = {l[W-1], l} + {r[W-1], r};
    avg  = sum[W:1];
    diff = avg - c;
    return c + (diff >>> STIFF_SHIFT);
  endfunction

  // Left/right neighbours of every node; chain ends see the latched boundary.
  logic signed [W-1:0] nbr_l_x [N];
  logic signed [W-1:0] nbr_l_y [N];
  logic signed [W-1:0] nbr_r_x [N];
  logic signed [W-1:0] nbr_r_y [N];

  for (genvar g = 0; g < N; g++) begin : g_nbr
    if (g == 0) begin : g_left_edge
      assign nbr_l_x[g] = bl_x_q;
      assign nbr_l_y[g] = bl_y_q;
    end else begin : g_left_node
      assign nbr_l_x[g] = x_q[g-1];
      assign nbr_l_y[g] = y_q[g-1];
    end
    if (g == N - 1) begin : g_right_edge
      assign nbr_r_x[g] = br_x_q;
      assign nbr_r_y[g] = br_y_q;
    end else begin : g_right_node
      assign nbr_r_x[g] = x_q[g+1];
      assign nbr_r_y[g] = y_q[g+1];
    end
  end

  // Next-state and datapath. Only node k_q is written in a given cycle, so the
  // node k-1 read during RELAX already holds this sweep's result (Gauss-Seidel).
  // Pins are sampled live, so a pin change applies from the next node onward.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    it_d    = it_q;
    x_d     = x_q;
    y_d     = y_q;
    px_d    = px_q;
    py_d    = py_q;
    bl_x_d  = bl_x_q;
    bl_y_d  = bl_y_q;
    br_x_d  = br_x_q;
    br_y_d  = br_y_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_INTEGRATE;
          k_d     = '0;
          it_d    = '0;
          bl_x_d  = bus.prev_last_x;
          bl_y_d  = bus.prev_last_y;
          br_x_d  = bus.next_first_x;
          br_y_d  = bus.next_first_y;
        end
      end

      S_INTEGRATE: begin
        for (int i = 0; i < N; i++) begin
          if (k_q == KW'(i) &&
              !((i == 0 && bus.pin_first) || (i == N - 1 && bus.pin_last))) begin
            px_d[i] = x_q[i];
            py_d[i] = y_q[i];
            x_d[i]  = integ_f(x_q[i], px_q[i]);
            y_d[i]  = integ_f(y_q[i], py_q[i]) + ACC_Y;
          end
        end
        if (k_q == KW'(N - 1)) begin
          k_d     = '0;
          state_d = S_RELAX;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      S_RELAX: begin
        for (int i = 0; i < N; i++) begin
          if (k_q == KW'(i) &&
              !((i == 0 && bus.pin_first) || (i == N - 1 && bus.pin_last))) begin
            x_d[i] = relax_f(nbr_l_x[i], nbr_r_x[i], x_q[i]);
            y_d[i] = relax_f(nbr_l_y[i], nbr_r_y[i], y_q[i]);
          end
        end
        if (k_q == KW'(N - 1)) begin
          k_d = '0;
          if (it_q == IW'(ITERS - 1)) begin
            state_d = S_DONE;
          end else begin
            it_d = it_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      S_DONE: begin
        // start is deliberately not examined here
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset restores the evenly spaced, motionless chain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      it_q    <= '0;
      for (int i = 0; i < N; i++) begin
        x_q[i]  <= W'(i) * SPACING;
        px_q[i] <= W'(i) * SPACING;
        y_q[i]  <= '0;
        py_q[i] <= '0;
      end
      bl_x_q <= '0;
      bl_y_q <= '0;
      br_x_q <= '0;
      br_y_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      it_q    <= it_d;
      x_q     <= x_d;
      y_q     <= y_d;
      px_q    <= px_d;
      py_q    <= py_d;
      bl_x_q  <= bl_x_d;
      bl_y_q  <= bl_y_d;
      br_x_q  <= br_x_d;
      br_y_q  <= br_y_d;
    end
  end

  // Readout mux; indices beyond the chain read as zero.
  logic signed [W-1:0] rd_x_c, rd_y_c;

  always_comb begin
    rd_x_c = '0;
    rd_y_c = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.rd_idx == KW'(i)) begin
        rd_x_c = x_q[i];
        rd_y_c = y_q[i];
      end
    end
  end

  assign bus.rd_x    = rd_x_c;
  assign bus.rd_y    = rd_y_c;
  assign bus.busy    = (state_q == S_INTEGRATE) || (state_q == S_RELAX);
  assign bus.done    = (state_q == S_DONE);
  assign bus.first_x = x_q[0];
  assign bus.first_y = y_q[0];
  assign bus.last_x  = x_q[N-1];
  assign bus.last_y  = y_q[N-1];

endmodule

// File: tb/tb_verlet_chain_core.sv
module tb_verlet_chain_core;
  localparam int N        = 4;
  localparam int W        = 32;
  localparam int ITERS    = 1;
  localparam int SS       = 0;
  localparam int DS       = 1;
  localparam int STEP_CYC = N + ITERS * N;          // busy periods per step
  localparam logic signed [31:0] SPACE = 32'sh0001_0000;
  localparam logic signed [31:0] ACC   = -32'sh100;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;

  verlet_chain_if #(.N(N), .W(W)) bus ();

  verlet_chain_core #(
    .N(N), .W(W), .SPACING(32'h0001_0000), .ACC_Y(-32'sh100),
    .ITERS(ITERS), .STIFF_SHIFT(SS), .DAMP_SHIFT(DS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking bookkeeping ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct packed {
    int               a;      // first busy period
    int               dc;     // done period
    logic [3:0][31:0] ex;
    logic [3:0][31:0] ey;
  } exp_t;

  exp_t sb_q[$];
  int   req_cnt = 0;          // driver asks the monitor for a reset-value sweep
  int   ack_cnt = 0;
  int   free_p  = 0;          // first period in which a start would be accepted

  // ---------------- behavioural reference model ----------------
  logic signed [31:0] mx [N];
  logic signed [31:0] my [N];
  logic signed [31:0] mpx[N];
  logic signed [31:0] mpy[N];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i]  = 32'(i * 32'h10000);
      mpx[i] = mx[i];
      my[i]  = 0;
      mpy[i] = 0;
    end
  endfunction

  function automatic logic signed [31:0] m_integ(input logic signed [31:0] c, input logic signed [31:0] p);
`ifdef VERLET_DAMP_EN
    logic signed [31:0] v;
    v = c - p;
    return c + v - (v >>> DS);
`else
    return 32'(2 * longint'(c) - longint'(p));
`endif
  endfunction

  function automatic logic signed [31:0] m_relax(input logic signed [31:0] l, input logic signed [31:0] r,
                                                 input logic signed [31:0] c);
    longint             s;
    logic signed [31:0] avg, d;
    s   = longint'(l) + longint'(r);
    avg = 32'(s >>> 1);                // floor of the exact midpoint
    d   = avg - c;
    return c + (d >>> SS);
  endfunction

  function automatic void model_step(input logic pf, input logic pl,
                                     input logic signed [31:0] lx, input logic signed [31:0] ly,
                                     input logic signed [31:0] rx, input logic signed [31:0] ry);
    logic signed [31:0] nx, ny, l_x, l_y, r_x, r_y;
    for (int k = 0; k < N; k++) begin
      if (!((k == 0 && pf) || (k == N - 1 && pl))) begin
        nx = m_integ(mx[k], mpx[k]);
        ny = m_integ(my[k], mpy[k]) + ACC;
        mpx[k] = mx[k]; mpy[k] = my[k];
        mx[k]  = nx;    my[k]  = ny;
      end
    end
    for (int it = 0; it < ITERS; it++) begin
      for (int k = 0; k < N; k++) begin
        if (!((k == 0 && pf) || (k == N - 1 && pl))) begin
          if (k == 0) begin l_x = lx; l_y = ly; end
          else begin l_x = mx[k-1]; l_y = my[k-1]; end
          if (k == N - 1) begin r_x = rx; r_y = ry; end
          else begin r_x = mx[k+1]; r_y = my[k+1]; end
          mx[k] = m_relax(l_x, r_x, mx[k]);
          my[k] = m_relax(l_y, r_y, my[k]);
        end
      end
    end
  endfunction

  // ---------------- driver helpers ----------------
  logic              lit_en = 1'b0;   // use hand-derived expectations instead of the model
  logic [3:0][31:0]  lit_x, lit_y;

  // One period of stimulus; inputs change 1 time unit after the rising edge.
  task automatic issue_cycle(input logic st);
    exp_t e;
    bus.start = st;
    if (st && cyc >= free_p) begin
      model_step(bus.pin_first, bus.pin_last, bus.prev_last_x, bus.prev_last_y,
                 bus.next_first_x, bus.next_first_y);
      e.a  = cyc + 1;
      e.dc = cyc + 1 + STEP_CYC;
      for (int i = 0; i < N; i++) begin
        e.ex[i] = lit_en ? lit_x[i] : mx[i];
        e.ey[i] = lit_en ? lit_y[i] : my[i];
      end
      sb_q.push_back(e);
      free_p = cyc + STEP_CYC + 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    sb_q.delete();
    model_reset();
    reset  = 1'b1;
    free_p = cyc;
    req_cnt++;
    issue_cycle(1'b0);
  endtask

  task automatic wait_idle();
    for (int g = 0; g < 100 && cyc < free_p; g++) issue_cycle(1'b0);
  endtask

  task automatic set_bounds(input logic signed [31:0] lx, input logic signed [31:0] ly,
                            input logic signed [31:0] rx, input logic signed [31:0] ry);
    bus.prev_last_x = lx; bus.prev_last_y = ly;
    bus.next_first_x = rx; bus.next_first_y = ry;
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic sweep(input string tag, input logic [3:0][31:0] ex, input logic [3:0][31:0] ey);
    for (int i = 0; i < N; i++) begin
      bus.rd_idx = 2'(i);
      #1;
      chk($sformatf("%s rd_x[%0d]", tag, i), bus.rd_x, ex[i]);
      chk($sformatf("%s rd_y[%0d]", tag, i), bus.rd_y, ey[i]);
    end
    chk({tag, " first_x"}, bus.first_x, ex[0]);
    chk({tag, " first_y"}, bus.first_y, ey[0]);
    chk({tag, " last_x"},  bus.last_x,  ex[N-1]);
    chk({tag, " last_y"},  bus.last_y,  ey[N-1]);
  endtask

  initial begin : monitor
    exp_t             e;
    logic             eb, ed;
    logic [3:0][31:0] rx, ry;
    bus.rd_idx = '0;
    @(posedge clk);
    @(posedge clk);
    forever begin
      @(negedge clk);
      eb = (sb_q.size() > 0) && (cyc >= sb_q[0].a) && (cyc < sb_q[0].dc);
      ed = (sb_q.size() > 0) && (cyc == sb_q[0].dc);
      chk("busy", 32'(bus.busy), 32'(eb));
      chk("done", 32'(bus.done), 32'(ed));
      if (ed) begin
        e = sb_q.pop_front();
        sweep("step", e.ex, e.ey);
      end else if (req_cnt != ack_cnt) begin
        ack_cnt = req_cnt;
        for (int i = 0; i < N; i++) begin
          rx[i] = 32'(i * 32'h10000);
          ry[i] = '0;
        end
        sweep("reset", rx, ry);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : driver
    bus.start = 1'b0;
    bus.pin_first = 1'b0;
    bus.pin_last  = 1'b0;
    set_bounds(-32'sh10000, 0, 32'sh40000, 0);

    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    reset  = 1'b1;
    free_p = cyc;
    req_cnt++;
    issue_cycle(1'b0);
    issue_cycle(1'b0);

    // 2: unpinned step with hand-derived result, then two more (damping preload)
    lit_x = {32'h30000, 32'h20000, 32'h10000, 32'h0};
    lit_y = {-32'sh70, -32'shE0, -32'shC0, -32'sh80};
    lit_en = 1'b1;
    issue_cycle(1'b1);
    lit_en = 1'b0;
    wait_idle();
    issue_cycle(1'b1);
    wait_idle();
    issue_cycle(1'b1);
    wait_idle();

    // 3: both ends pinned, from reset
    do_reset();
    bus.pin_first = 1'b1;
    bus.pin_last  = 1'b1;
    lit_x = {32'h30000, 32'h20000, 32'h10000, 32'h0};
    lit_y = {32'h0, -32'sh40, -32'sh80, 32'h0};
    lit_en = 1'b1;
    issue_cycle(1'b1);
    lit_en = 1'b0;
    wait_idle();
    bus.pin_first = 1'b0;
    bus.pin_last  = 1'b0;

    // 4: start held for 20 periods -> accepted twice, 10 periods apart
    issue_cycle(1'b0);
    for (int i = 0; i < 20; i++) issue_cycle(1'b1);
    issue_cycle(1'b0);
    wait_idle();

    // 5: reset during the sixth busy period discards the step
    issue_cycle(1'b1);
    for (int g = 0; g < 20 && cyc < free_p - STEP_CYC - 1 + 5; g++) issue_cycle(1'b0);
    do_reset();
    issue_cycle(1'b0);

    // random: boundaries/pins change only while idle; start toggles freely
    for (int n = 0; n < 400; n++) begin
      if (cyc >= free_p) begin
        bus.pin_first = ($urandom_range(0, 3) == 0);
        bus.pin_last  = ($urandom_range(0, 3) == 0);
        set_bounds($signed(32'($urandom_range(0, 32'h80000))) - 32'sh40000,
                   $signed(32'($urandom_range(0, 32'h8000))) - 32'sh4000,
                   $signed(32'($urandom_range(0, 32'h80000))) - 32'sh40000,
                   $signed(32'($urandom_range(0, 32'h8000))) - 32'sh4000);
      end
      issue_cycle($urandom_range(0, 2) == 0);
    end

    // drain
    for (int g = 0; g < 100 && sb_q.size() > 0; g++) issue_cycle(1'b0);
    chk("drain", 32'(sb_q.size()), 32'd0);
    issue_cycle(1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/verlet_chain_core.md
Name: verlet_chain_core

Overview:
- Parametrised successor to the fixed-size rope core. Holds a chain of N point-mass nodes in registers.
- On each `start`, runs one simulation step: a Verlet integration sweep, then ITERS Gauss-Seidel relaxation sweeps against the neighbours.
- Exposes its end nodes and accepts the adjacent cores' end nodes, so several cores chain into one long rope.
- Adds a start/busy/done handshake, pinned endpoints and a random-access readout.

Parameters:
- N, 5, nodes per core (≥2).
- W, 32, signed fixed-point position width.
- SPACING, 32'h0001_0000, initial x pitch between nodes.
- ACC_Y, -32'sh100, per-step y acceleration term (g·dt², pre-scaled).
- ITERS, 2, relaxation sweeps per step (≥1).
- STIFF_SHIFT, 0, relaxation gain = 2^-STIFF_SHIFT.
- DAMP_SHIFT, 4, damping shift (used only with VERLET_DAMP_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- start  in  1  request one step; accepted only in IDLE.
- busy  out  1  high during INTEGRATE and RELAX.
- done  out  1  one-cycle pulse when a step completes.
- pin_first  in  1  node 0 is held fixed.
- pin_last  in  1  node N-1 is held fixed.
- prev_last_x, prev_last_y  in  W  last node of the left neighbour core.
- next_first_x, next_first_y  in  W  first node of the right neighbour core.
- first_x, first_y  out  W  node 0 position.
- last_x, last_y  out  W  node N-1 position.
- rd_idx  in  clog2(N)  readout select.
- rd_x, rd_y  out  W  position of node rd_idx (combinational).

Behaviour:
- Storage: x[i], y[i] (current) and px[i], py[i] (previous), i = 0..N-1.
- Reset (reset==0 at posedge):
  - x[i] = px[i] = i·SPACING; y[i] = py[i] = 0.
  - State IDLE; busy = 0; done = 0.
  - Applies from any state, including mid-step; the partial step is discarded.
- Arithmetic:
  - Signed two's complement, W bits, wrap-around, no saturation.
  - Shifts are arithmetic.
  - Sums are computed in W+1 bits before `>>>1`.
- FSM: IDLE → INTEGRATE → RELAX → DONE → IDLE.
- IDLE:
  - `start` = 1 at posedge t accepts the step.
  - The boundary inputs prev_last_*/next_first_* are latched at t.
- INTEGRATE, cycles t+1 .. t+N, node k = cycle index 0..N-1:
  - nx = 2x[k] − px[k]
  - ny = 2y[k] − py[k] + ACC_Y
  - px[k] ← x[k]; x[k] ← nx (likewise y).
  - A pinned node is left completely unchanged, including px/py.
- RELAX, ITERS·N cycles, node k sweeps 0..N-1 ascending, repeated ITERS times:
  - L = x[k-1], or the latched prev_last_x when k = 0.
  - R = x[k+1], or the latched next_first_x when k = N-1.
  - x[k] ← x[k] + ((((L + R) >>> 1) − x[k]) >>> STIFF_SHIFT); y the same.
  - Gauss-Seidel: node k uses the already-updated node k-1 from the same sweep.
  - Pinned nodes are skipped; px/py are not touched in RELAX.
- DONE: single cycle, cycle t+N+ITERS·N+1.
  - done = 1, busy = 0.
  - `start` is ignored in DONE; the state returns to IDLE.
- Handshake:
  - `start` asserted while busy or in DONE is ignored (not queued).
  - busy rises on cycle t+1 and falls on the DONE cycle.
- Changing pin_* mid-step takes effect from the next node processed.
- Outputs first_*, last_*, rd_* track the registers live and may change during a step.
- rd_idx ≥ N returns 0.

Optional Feature:
- Macro: VERLET_DAMP_EN.
- Defined: integration uses
  - v = x − px
  - nx = x + v − (v >>> DAMP_SHIFT) (likewise y, then + ACC_Y).
- Undefined: the undamped formula above; DAMP_SHIFT is unused.
- All other behaviour is identical in both builds.

Test Plan:
Common setup: N=4, W=32, ITERS=1, STIFF_SHIFT=0, SPACING=0x10000, ACC_Y=−0x100, macro undefined.
- 1. Reset then idle → rd_x for idx 0..3 = 0, 0x10000, 0x20000, 0x30000; all y = 0; busy = 0; done = 0.
- 2. Unpinned; prev_last = (−0x10000, 0); next_first = (0x40000, 0); start at t:
  - busy high for cycles t+1..t+8; done pulses at t+9.
  - x unchanged.
  - y = −0x80, −0xC0, −0xE0, −0x70.
  - py of every node = 0.
- 3. From reset, pin_first = pin_last = 1, start:
  - node0 and node3 y = 0 and unchanged.
  - node1 y = −0x80; node2 y = −0x40.
- 4. Hold start high for 20 cycles from idle → exactly two done pulses, 10 cycles apart. Starts during busy and DONE are ignored.
- 5. Assert reset at cycle t+6 of a step → next cycle busy = 0, positions equal the reset values, no done pulse.
- 6. Build with VERLET_DAMP_EN, DAMP_SHIFT=1:
  - Preload by running scenario 2 twice, then a third step.
  - Compare node1 y against a golden model; must differ from the undamped build's value.
